// File: rtl/vx_sa_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vx_sa_feeder : latches an NxN A/B tile pair and streams it diagonally skewed
//                into a systolic array. Rev 1.0
// ---------------------------------------------------------------------------
module vx_sa_feeder #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          req_valid,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0]  req_a,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0]  req_b,
  output logic                                          req_ready,
  input  logic                                          flush,
  output logic                                          sa_clear,
  output logic                                          sa_valid,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0]              sa_in_a,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0]              sa_in_b,
  output logic                                          busy,
  output logic                                          done
);

  localparam int N  = MATRIX_SIZE;
  localparam int DW = DATA_SIZE;
  localparam int CW = ($clog2(2*N) < 1) ? 1 : $clog2(2*N);

  localparam logic [CW-1:0] FEED_LAST  = CW'(2*N-2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N-1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N*N*DW-1:0]   a_q, b_q;
  logic                accept;
  logic [31:0]         t_w;

  // flush has priority over an accept in the same cycle
  assign req_ready = ((state_q == S_IDLE) || (state_q == S_DONE)) && !flush;
  assign accept    = req_ready && req_valid;
  assign sa_clear  = (state_q == S_CLEAR);
  assign sa_valid  = (state_q == S_FEED);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign t_w       = 32'(cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        cnt_d   = '0;
      end
      S_FEED: begin
        if (cnt_q == FEED_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = accept ? S_CLEAR : S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= req_a;
      b_q <= req_b;
    end
  end

  // Lane i carries element k = t - i; everything outside that window is zero
  always_comb begin
    sa_in_a = '0;
    sa_in_b = '0;
    if (state_q == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (t_w == 32'(i + k)) begin
            sa_in_a[i*DW +: DW] = a_q[(i*N+k)*DW +: DW];
            sa_in_b[i*DW +: DW] = b_q[(k*N+i)*DW +: DW];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vx_sa_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vx_sa_feeder : directed bench for vx_sa_feeder (N=2 and N=1 instances).
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vx_sa_feeder;

  logic         clk = 1'b0;
  logic         reset2, req_valid2, flush2;
  logic [127:0] req_a2, req_b2;
  logic         req_ready2, sa_clear2, sa_valid2, busy2, done2;
  logic [63:0]  sa_in_a2, sa_in_b2;

  logic         reset1, req_valid1, flush1;
  logic [31:0]  req_a1, req_b1;
  logic         req_ready1, sa_clear1, sa_valid1, busy1, done1;
  logic [31:0]  sa_in_a1, sa_in_b1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  vx_sa_feeder #(.MATRIX_SIZE(2), .DATA_SIZE(32)) u2 (
    .clk(clk), .reset(reset2), .req_valid(req_valid2), .req_a(req_a2), .req_b(req_b2),
    .req_ready(req_ready2), .flush(flush2), .sa_clear(sa_clear2), .sa_valid(sa_valid2),
    .sa_in_a(sa_in_a2), .sa_in_b(sa_in_b2), .busy(busy2), .done(done2)
  );

  vx_sa_feeder #(.MATRIX_SIZE(1), .DATA_SIZE(32)) u1 (
    .clk(clk), .reset(reset1), .req_valid(req_valid1), .req_a(req_a1), .req_b(req_b1),
    .req_ready(req_ready1), .flush(flush1), .sa_clear(sa_clear1), .sa_valid(sa_valid1),
    .sa_in_a(sa_in_a1), .sa_in_b(sa_in_b1), .busy(busy1), .done(done1)
  );

  // 2x2 output-stationary array with one register hop per PE
  logic [31:0] pa00, pa01, pa10, pa11, pb00, pb01, pb10, pb11;
  logic [31:0] acc00, acc01, acc10, acc11;
  logic [31:0] ain0, ain1, bin0, bin1;
  assign ain0 = sa_in_a2[31:0];
  assign ain1 = sa_in_a2[63:32];
  assign bin0 = sa_in_b2[31:0];
  assign bin1 = sa_in_b2[63:32];

  always @(posedge clk) begin
    if (sa_clear2) begin
      pa00 <= 0; pa01 <= 0; pa10 <= 0; pa11 <= 0;
      pb00 <= 0; pb01 <= 0; pb10 <= 0; pb11 <= 0;
      acc00 <= 0; acc01 <= 0; acc10 <= 0; acc11 <= 0;
    end else begin
      pa00 <= ain0; pb00 <= bin0; acc00 <= acc00 + ain0 * bin0;
      pa01 <= pa00; pb01 <= bin1; acc01 <= acc01 + pa00 * bin1;
      pa10 <= ain1; pb10 <= pb00; acc10 <= acc10 + ain1 * pb00;
      pa11 <= pa10; pb11 <= pb01; acc11 <= acc11 + pa10 * pb01;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle2(input string tag);
    chk({tag, ".ready"}, {63'd0, req_ready2}, 64'd1);
    chk({tag, ".busy"},  {63'd0, busy2},      64'd0);
    chk({tag, ".clear"}, {63'd0, sa_clear2},  64'd0);
    chk({tag, ".valid"}, {63'd0, sa_valid2},  64'd0);
    chk({tag, ".in_a"},  sa_in_a2,            64'd0);
    chk({tag, ".in_b"},  sa_in_b2,            64'd0);
    chk({tag, ".done"},  {63'd0, done2},      64'd0);
  endtask

  task automatic chk_res(input string tag, input logic [31:0] r00, input logic [31:0] r01,
                         input logic [31:0] r10, input logic [31:0] r11);
    chk({tag, ".c00"}, {32'd0, acc00}, {32'd0, r00});
    chk({tag, ".c01"}, {32'd0, acc01}, {32'd0, r01});
    chk({tag, ".c10"}, {32'd0, acc10}, {32'd0, r10});
    chk({tag, ".c11"}, {32'd0, acc11}, {32'd0, r11});
  endtask

  initial begin
    reset2 = 1'b0; req_valid2 = 1'b0; flush2 = 1'b0; req_a2 = '0; req_b2 = '0;
    reset1 = 1'b0; req_valid1 = 1'b0; flush1 = 1'b0; req_a1 = '0; req_b1 = '0;
    #1;

    // Reset held for three cycles, then released
    chk_idle2("rst_during");
    for (int c = 0; c < 3; c++) tick();
    chk_idle2("rst_held");
    reset2 = 1'b1; reset1 = 1'b1;
    tick();
    chk_idle2("rst_after");

    // Skew: A=[[1,2],[3,4]], B=[[5,6],[7,8]]
    req_a2 = {32'd4, 32'd3, 32'd2, 32'd1};
    req_b2 = {32'd8, 32'd7, 32'd6, 32'd5};
    req_valid2 = 1'b1;
    tick();                                   // cycle 1
    req_valid2 = 1'b0;
    chk("skew.c1.clear", {63'd0, sa_clear2}, 64'd1);
    chk("skew.c1.ready", {63'd0, req_ready2}, 64'd0);
    tick();                                   // cycle 2
    chk("skew.c2.valid", {63'd0, sa_valid2}, 64'd1);
    chk("skew.c2.a", sa_in_a2, {32'd0, 32'd1});
    chk("skew.c2.b", sa_in_b2, {32'd0, 32'd5});
    tick();                                   // cycle 3
    chk("skew.c3.a", sa_in_a2, {32'd3, 32'd2});
    chk("skew.c3.b", sa_in_b2, {32'd6, 32'd7});
    tick();                                   // cycle 4
    chk("skew.c4.a", sa_in_a2, {32'd4, 32'd0});
    chk("skew.c4.b", sa_in_b2, {32'd8, 32'd0});
    tick();                                   // cycle 5
    chk("skew.c5.valid", {63'd0, sa_valid2}, 64'd0);
    chk("skew.c5.a", sa_in_a2, 64'd0);
    tick();                                   // cycle 6
    chk("skew.c6.done", {63'd0, done2}, 64'd0);
    chk("skew.c6.busy", {63'd0, busy2}, 64'd1);
    tick();                                   // cycle 7
    chk("skew.c7.done", {63'd0, done2}, 64'd1);
    chk("skew.c7.ready", {63'd0, req_ready2}, 64'd1);
    chk_res("skew.res", 32'd19, 32'd22, 32'd43, 32'd50);
    tick();                                   // cycle 8
    chk_idle2("skew.idle");

    // Back-to-back: first pair A=I, B=[[2,3],[4,5]]; second pair as in skew test
    req_a2 = {32'd1, 32'd0, 32'd0, 32'd1};
    req_b2 = {32'd5, 32'd4, 32'd3, 32'd2};
    req_valid2 = 1'b1;
    tick();                                   // cycle 1
    req_a2 = {32'd4, 32'd3, 32'd2, 32'd1};
    req_b2 = {32'd8, 32'd7, 32'd6, 32'd5};
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("b2b.c%0d.ready", c), {63'd0, req_ready2}, 64'd0);
      if (c == 2) begin
        chk("b2b.c2.a", sa_in_a2, {32'd0, 32'd1});
        chk("b2b.c2.b", sa_in_b2, {32'd0, 32'd2});
      end
      if (c == 3) begin
        chk("b2b.c3.a", sa_in_a2, 64'd0);
        chk("b2b.c3.b", sa_in_b2, {32'd3, 32'd4});
      end
      tick();
    end
    chk("b2b.c7.done", {63'd0, done2}, 64'd1);
    chk("b2b.c7.ready", {63'd0, req_ready2}, 64'd1);
    chk_res("b2b.res1", 32'd2, 32'd3, 32'd4, 32'd5);
    tick();                                   // cycle 8
    req_valid2 = 1'b0;
    chk("b2b.c8.clear", {63'd0, sa_clear2}, 64'd1);
    for (int c = 9; c <= 13; c++) begin
      tick();
      chk($sformatf("b2b.c%0d.done", c), {63'd0, done2}, 64'd0);
    end
    tick();                                   // cycle 14
    chk("b2b.c14.done", {63'd0, done2}, 64'd1);
    chk_res("b2b.res2", 32'd19, 32'd22, 32'd43, 32'd50);
    tick();
    chk_idle2("b2b.idle");

    // Flush in FEED cycle 3, with req_valid held high
    req_valid2 = 1'b1;
    tick();                                   // cycle 1
    req_valid2 = 1'b0;
    tick();                                   // cycle 2
    tick();                                   // cycle 3
    chk("flush.c3.valid", {63'd0, sa_valid2}, 64'd1);
    flush2 = 1'b1;
    req_valid2 = 1'b1;
    tick();                                   // cycle 4
    chk("flush.c4.busy", {63'd0, busy2}, 64'd0);
    chk("flush.c4.ready", {63'd0, req_ready2}, 64'd0);
    chk("flush.c4.valid", {63'd0, sa_valid2}, 64'd0);
    chk("flush.c4.a", sa_in_a2, 64'd0);
    tick();                                   // cycle 5
    chk("flush.c5.busy", {63'd0, busy2}, 64'd0);
    chk("flush.c5.clear", {63'd0, sa_clear2}, 64'd0);
    flush2 = 1'b0;
    req_valid2 = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      tick();
      chk($sformatf("flush.c%0d.done", c), {63'd0, done2}, 64'd0);
    end

    // Async reset mid-DRAIN
    req_valid2 = 1'b1;
    tick();                                   // cycle 1
    req_valid2 = 1'b0;
    for (int c = 2; c <= 5; c++) tick();      // cycle 5
    chk("arst.c5.busy_before", {63'd0, busy2}, 64'd1);
    #2;
    reset2 = 1'b0;
    #1;
    chk("arst.busy_now", {63'd0, busy2}, 64'd0);
    chk("arst.ready_now", {63'd0, req_ready2}, 64'd1);
    tick();
    reset2 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("arst.post%0d.done", c), {63'd0, done2}, 64'd0);
    end
    req_a2 = {32'd2, 32'd0, 32'd0, 32'd2};
    req_b2 = {32'd8, 32'd7, 32'd6, 32'd5};
    req_valid2 = 1'b1;
    tick();                                   // cycle 1
    req_valid2 = 1'b0;
    chk("arst.fresh.clear", {63'd0, sa_clear2}, 64'd1);
    for (int c = 2; c <= 7; c++) tick();      // cycle 7
    chk("arst.fresh.done", {63'd0, done2}, 64'd1);
    chk_res("arst.fresh.res", 32'd10, 32'd12, 32'd14, 32'd16);

    // N=1: A=[9], B=[3]; req_a/req_b changed while not accepting
    req_a1 = 32'd9;
    req_b1 = 32'd3;
    req_valid1 = 1'b1;
    tick();                                   // cycle 1
    req_valid1 = 1'b0;
    req_a1 = 32'd5;
    req_b1 = 32'd7;
    chk("n1.c1.clear", {63'd0, sa_clear1}, 64'd1);
    tick();                                   // cycle 2
    chk("n1.c2.valid", {63'd0, sa_valid1}, 64'd1);
    chk("n1.c2.a", {32'd0, sa_in_a1}, 64'd9);
    chk("n1.c2.b", {32'd0, sa_in_b1}, 64'd3);
    tick();                                   // cycle 3
    chk("n1.c3.a", {32'd0, sa_in_a1}, 64'd0);
    chk("n1.c3.done", {63'd0, done1}, 64'd0);
    tick();                                   // cycle 4
    chk("n1.c4.done", {63'd0, done1}, 64'd1);
    tick();
    chk("n1.idle.busy", {63'd0, busy1}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vx_sa_feeder.md
# VX_sa_feeder

Operand feeder for the execute-stage systolic array. Accepts one pair of NxN operand tiles (A, B) per handshake and latches them. Emits them as diagonally skewed row and column streams on the array's left and top edges, with zero padding outside each lane's window. Clears the array accumulators beforehand and signals when the array's result matrix is stable. Sits directly upstream of `VX_systolic_array`, which it drives every cycle.

## Interface
Parameters:
- `MATRIX_SIZE`, 2, N; tile dimension and array dimension, N >= 1.
- `DATA_SIZE`, 32, DW; element width in bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  operand tiles valid.
- `req_a`  in  N*N*DW  matrix A, row-major; A[i][k] at bits [(i*N+k)*DW +: DW].
- `req_b`  in  N*N*DW  matrix B, row-major; B[k][j] at bits [(k*N+j)*DW +: DW].
- `req_ready`  out  1  feeder can accept a request.
- `flush`  in  1  synchronous abort of the current operation.
- `sa_clear`  out  1  one-cycle clear of the array accumulators and pipeline registers.
- `sa_valid`  out  1  high during feed cycles.
- `sa_in_a`  out  N*DW  left-edge inputs; row i at [i*DW +: DW].
- `sa_in_b`  out  N*DW  top-edge inputs; column j at [j*DW +: DW].
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse; the array result is stable.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- Counter `cnt`, width $clog2(2N) (minimum 1), resets to 0 on every state entry.
- **IDLE**
  - `req_ready`=1.
  - Accept (`req_valid`&&`req_ready`): latch `req_a`/`req_b` into internal registers, go to CLEAR.
- **CLEAR** (1 cycle): `sa_clear`=1, then FEED.
- **FEED** (2N-1 cycles, `cnt`=t from 0 to 2N-2): `sa_valid`=1.
  - Row i: `sa_in_a[i]` = A[i][t-i] if 0 <= t-i < N, else 0.
  - Column j: `sa_in_b[j]` = B[t-j][j] if 0 <= t-j < N, else 0.
  - After t=2N-2, go to DRAIN.
- **DRAIN** (N cycles): `sa_in_a`/`sa_in_b`=0, `sa_valid`=0. Then go to DONE.
- **DONE** (1 cycle): `done`=1, `req_ready`=1.
  - Accept in this cycle: latch operands, go to CLEAR, giving back-to-back operation.
  - Otherwise go to IDLE.
- Outside FEED, `sa_in_a`/`sa_in_b` are 0.
- Latched operands are not changed by input activity while not accepting.
- `flush`=1 in any state: next state IDLE; no `done` for the aborted operation.
  - `flush` beats accept: `req_ready` is forced to 0 while `flush`=1.
- Reset (async, active-low) mid-operation: state IDLE, `cnt`=0, operand registers 0 immediately. No `done` pulse.
- Reset values:
  - `sa_clear`=0, `sa_valid`=0, `sa_in_a`=0, `sa_in_b`=0, `busy`=0, `done`=0.
  - `req_ready`=1, since it is decoded from state IDLE.
- All outputs are registered or decoded directly from the state register and `cnt`, with no combinational path from `req_*` to outputs. Exception: `req_ready` depends on `flush`.

## Timing
- Accept edge = cycle 0. CLEAR = cycle 1. FEED = cycles 2..2N. DRAIN = cycles 2N+1..3N. DONE = cycle 3N+1.
- For N=2: `done` is asserted in cycle 7.
- Timing is derived for an array with one register hop per PE:
  - Element k meets at PE(i,j) at feed-relative cycle i+j+k, so the last meet is at 3N-3.
  - The MAC result is registered one cycle later, leaving 1 cycle of slack before DONE.
- Throughput: one tile pair per 3N+1 cycles with back-to-back accepts in DONE.
- N=1: FEED 1 cycle, DRAIN 1 cycle, DONE in cycle 4.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles, then release. Required: `req_ready`=1, `busy`=0, and all other outputs 0 during and after reset.
- **Skew, N=2:** A=[[1,2],[3,4]], B=[[5,6],[7,8]], accept at cycle 0. Required:
  - `sa_clear` in cycle 1.
  - `sa_in_a` (row0,row1) = (1,0), (2,3), (0,4) in cycles 2–4.
  - `sa_in_b` (col0,col1) = (5,0), (7,6), (0,8) in cycles 2–4.
  - `done` in cycle 7.
  - Array output [[19,22],[43,50]].
- **Back-to-back:** hold `req_valid`=1 with a second tile pair. Required: accept in the DONE cycle 7, `sa_clear` in cycle 8, second `done` in cycle 14, and `req_ready`=0 in cycles 1–6.
- **Flush:** assert `flush` in FEED cycle 3. Required: IDLE in cycle 4, outputs 0, no `done`. With `req_valid`=1 during `flush`, no accept occurs.
- **Async reset mid-DRAIN:** pull `reset` low between edges in cycle 5. Required: `busy`=0 immediately (no clock edge needed), no `done`, and a fresh accept works afterwards.
- **N=1 and hold:** with N=1, A=[9], B=[3], required: `sa_in_a`=9 and `sa_in_b`=3 in cycle 2, `done` in cycle 4. Separately, change `req_a` while not accepting; the streamed data must be unchanged.
